// File: rtl/trace_arbiter.sv
// Round-robin trace arbiter: each tile has a one-word holding register that is drained
// into the shared trace_buffer write port at one word per cycle, tagged with its source tile.
module trace_arbiter #(
  parameter int Fpay     = 32,
  parameter int Tile_num = 4,
  parameter int DROPw    = 8,
  parameter int IDw      = $clog2(Tile_num)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [Tile_num*Fpay-1:0]  din_all,
  input  logic [Tile_num-1:0]       wr_all,
  input  logic [Tile_num-1:0]       ip_select,
  input  logic                      tb_full,
  input  logic                      clear_cnt,
  output logic                      wr_en,
  output logic [Fpay-1:0]           dout,
  output logic [IDw-1:0]            src_id,
  output logic [Tile_num-1:0]       pend_all,
  output logic [Tile_num*DROPw-1:0] drop_cnt_all
);

  logic [Fpay-1:0]     hold_p0 [Tile_num];
  logic [DROPw-1:0]    drop_cnt [Tile_num];
  logic [IDw-1:0]      last_gnt;
  logic                gnt_vld;
  logic [IDw-1:0]      gnt_id;
  logic [Tile_num-1:0] gnt_oh;
  logic [Tile_num-1:0] cap;
  logic [Tile_num-1:0] acc;
  logic [Tile_num-1:0] drp;

  function automatic logic [DROPw-1:0] sat_inc(input logic [DROPw-1:0] v);
    return (v == {DROPw{1'b1}}) ? v : v + 1'b1;
  endfunction

  // Search starts one past the last grant so every pending tile is served within Tile_num cycles.
  always_comb begin
    logic [IDw-1:0] cand;
    gnt_vld = 1'b0;
    gnt_id  = '0;
    cand    = '0;
    if (!tb_full) begin
      for (int k = 1; k <= Tile_num; k++) begin
        cand = IDw'((int'(last_gnt) + k) % Tile_num);
        if (!gnt_vld && pend_all[cand]) begin
          gnt_vld = 1'b1;
          gnt_id  = cand;
        end
      end
    end
  end

  // A tile being drained this cycle may refill its holding register in the same cycle.
  always_comb begin
    gnt_oh = '0;
    for (int i = 0; i < Tile_num; i++)
      gnt_oh[i] = gnt_vld && (gnt_id == IDw'(i));
    cap = wr_all & ip_select;
    acc = cap & (~pend_all | gnt_oh);
    drp = cap & ~acc;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en    <= 1'b0;
      dout     <= '0;
      src_id   <= '0;
      pend_all <= '0;
      last_gnt <= IDw'(Tile_num - 1);
      for (int i = 0; i < Tile_num; i++) begin
        hold_p0[i]  <= '0;
        drop_cnt[i] <= '0;
      end
    end else begin
      wr_en <= gnt_vld;
      if (gnt_vld) begin
        dout     <= hold_p0[gnt_id];
        src_id   <= gnt_id;
        last_gnt <= gnt_id;
      end
      for (int i = 0; i < Tile_num; i++) begin
        if (acc[i])
          hold_p0[i] <= din_all[i*Fpay +: Fpay];
        pend_all[i] <= acc[i] | (pend_all[i] & ~gnt_oh[i]);
        if (clear_cnt)
          drop_cnt[i] <= '0;
        else if (drp[i])
          drop_cnt[i] <= sat_inc(drop_cnt[i]);
      end
    end
  end

  always_comb begin
    drop_cnt_all = '0;
    for (int i = 0; i < Tile_num; i++)
      drop_cnt_all[i*DROPw +: DROPw] = drop_cnt[i];
  end

endmodule

// File: tb/tb_trace_arbiter.sv
// Directed self-checking bench for trace_arbiter with the default 4 tiles, 32-bit words, 8-bit counters.
module tb_trace_arbiter;

  localparam int Fpay = 32;
  localparam int Tile_num = 4;
  localparam int DROPw = 8;
  localparam int IDw = 2;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [Tile_num*Fpay-1:0]  din_all;
  logic [Tile_num-1:0]       wr_all;
  logic [Tile_num-1:0]       ip_select;
  logic                      tb_full;
  logic                      clear_cnt;
  logic                      wr_en;
  logic [Fpay-1:0]           dout;
  logic [IDw-1:0]            src_id;
  logic [Tile_num-1:0]       pend_all;
  logic [Tile_num*DROPw-1:0] drop_cnt_all;

  int n_assert = 0;
  int n_fail = 0;

  trace_arbiter #(.Fpay(Fpay), .Tile_num(Tile_num), .DROPw(DROPw), .IDw(IDw)) dut (
    .clk(clk), .reset(reset), .din_all(din_all), .wr_all(wr_all), .ip_select(ip_select),
    .tb_full(tb_full), .clear_cnt(clear_cnt), .wr_en(wr_en), .dout(dout), .src_id(src_id),
    .pend_all(pend_all), .drop_cnt_all(drop_cnt_all)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    wr_all = '0;
    tb_full = 1'b0;
    clear_cnt = 1'b0;
    ip_select = 4'b1111;
    din_all = '0;
    tick();
    reset = 1'b0;
  endtask

  function automatic logic [63:0] cnt_of(input int t);
    return 64'(drop_cnt_all[t*DROPw +: DROPw]);
  endfunction

  initial begin
    do_reset();
    tick();
    check("rst_wr_en", wr_en, 0);
    check("rst_dout", dout, 0);
    check("rst_src_id", src_id, 0);
    check("rst_pend", pend_all, 0);
    check("rst_drop", drop_cnt_all, 0);

    // Single trigger on tile 2
    din_all[2*Fpay +: Fpay] = 32'hDEADBEEF;
    wr_all = 4'b0100;
    tick();
    check("t1_pend_set", pend_all, 4'b0100);
    check("t1_wr_early", wr_en, 0);
    wr_all = '0;
    tick();
    check("t1_wr_en", wr_en, 1);
    check("t1_dout", dout, 32'hDEADBEEF);
    check("t1_src", src_id, 2);
    check("t1_pend_clr", pend_all, 0);
    tick();
    check("t1_no_extra", wr_en, 0);
    check("t1_dout_hold", dout, 32'hDEADBEEF);

    // All tiles trigger together
    do_reset();
    for (int i = 0; i < Tile_num; i++) din_all[i*Fpay +: Fpay] = 32'hA0 + i;
    wr_all = 4'b1111;
    tick();
    check("t2_pend", pend_all, 4'b1111);
    wr_all = '0;
    for (int i = 0; i < Tile_num; i++) begin
      tick();
      check("t2_wr_en", wr_en, 1);
      check("t2_src", src_id, i);
      check("t2_dout", dout, 32'hA0 + i);
    end
    check("t2_pend_done", pend_all, 0);
    tick();
    check("t2_idle", wr_en, 0);
    check("t2_drops", drop_cnt_all, 0);

    // Continuous triggers for 40 cycles
    do_reset();
    for (int i = 0; i < Tile_num; i++) din_all[i*Fpay +: Fpay] = 32'hC0 + i;
    wr_all = 4'b1111;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (c == 1) begin
        check("t3_first", wr_en, 0);
      end else begin
        check("t3_wr_en", wr_en, 1);
        check("t3_src", src_id, (c - 2) % Tile_num);
      end
    end
    check("t3_drop0", cnt_of(0), 29);
    check("t3_drop1", cnt_of(1), 29);
    check("t3_drop2", cnt_of(2), 29);
    check("t3_drop3", cnt_of(3), 30);

    // Buffer full while tile 1 keeps triggering
    do_reset();
    tb_full = 1'b1;
    wr_all = 4'b0010;
    for (int c = 0; c < 5; c++) begin
      din_all[1*Fpay +: Fpay] = 32'h11 + c;
      tick();
      check("t4_full_wr", wr_en, 0);
    end
    check("t4_drop1", cnt_of(1), 4);
    check("t4_pend", pend_all, 4'b0010);
    wr_all = '0;
    tb_full = 1'b0;
    tick();
    check("t4_wr_en", wr_en, 1);
    check("t4_dout", dout, 32'h11);
    check("t4_src", src_id, 1);

    // Saturation and clear
    do_reset();
    tb_full = 1'b1;
    wr_all = 4'b0001;
    for (int c = 0; c < 256; c++) tick();
    check("t5_at_max", cnt_of(0), 255);
    for (int c = 0; c < 45; c++) tick();
    check("t5_sat", cnt_of(0), 255);
    clear_cnt = 1'b1;
    tick();
    check("t5_clear", cnt_of(0), 0);
    check("t5_pend_kept", pend_all, 4'b0001);
    clear_cnt = 1'b0;
    wr_all = '0;

    // Capture mask and mid-operation reset
    do_reset();
    ip_select = 4'b0111;
    wr_all = 4'b1000;
    tick();
    check("t6_masked_pend", pend_all, 0);
    check("t6_masked_drop", drop_cnt_all, 0);
    tick();
    check("t6_masked_wr", wr_en, 0);
    ip_select = 4'b1111;
    tb_full = 1'b1;
    wr_all = 4'b0011;
    din_all[0 +: Fpay] = 32'h55;
    tick();
    check("t6_pend01", pend_all, 4'b0011);
    wr_all = '0;
    tb_full = 1'b0;
    reset = 1'b1;
    tick();
    check("t6_rst_pend", pend_all, 0);
    check("t6_rst_wr", wr_en, 0);
    check("t6_rst_dout", dout, 0);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("t6_no_stale", wr_en, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/trace_arbiter.md
Name: trace_arbiter

Overview:
- Shares the single trace_buffer write port between the per-tile trace streams (trace_signal / trace_trigger) of the MPSoC tiles.
- Each tile has a one-word holding register. A round-robin scheduler drains the held words into the buffer at one word per cycle and tags each word with its source tile.
- The block stalls while the buffer reports full and counts the trace words it has to drop.
- It sits between the tiles' trace outputs and trace_buffer, and replaces the fixed-select trace_handler.

Parameters:
- Fpay, 32, width of one trace word.
- Tile_num, 4, number of trace sources (must be at least 2).
- DROPw, 8, width of each per-tile saturating drop counter.
- IDw, log2(Tile_num) (2 by default), width of the source tag.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- din_all  input  Tile_num*Fpay  trace words; tile i occupies bits [(i+1)*Fpay-1 : i*Fpay].
- wr_all  input  Tile_num  per-tile trace trigger; 1 = din word valid this cycle.
- ip_select  input  Tile_num  capture enable mask; 0 = ignore that tile's triggers.
- tb_full  input  1  trace buffer cannot accept a write this cycle.
- clear_cnt  input  1  single-cycle pulse that zeroes all drop counters.
- wr_en  output  1  registered write strobe to trace_buffer.
- dout  output  Fpay  registered trace word to trace_buffer.
- src_id  output  IDw  tile index of the word on dout.
- pend_all  output  Tile_num  holding-register-occupied flags.
- drop_cnt_all  output  Tile_num*DROPw  per-tile drop counters, packed like din_all.

Behaviour:
- Interface: one clock clk; reset is synchronous and active-high. All state updates on the rising edge of clk.
- Reset: wr_en=0, dout=0, src_id=0, pend_all=0, drop_cnt_all=0, holding registers=0, last-grant pointer=Tile_num-1 (so tile 0 has first priority).
- Capture, per tile i, when wr_all[i] & ip_select[i]:
  - If pend[i]=0, or pend[i]=1 and tile i is granted this cycle: hold[i] <= din word, pend[i] <= 1.
  - Otherwise: the new word is dropped, hold[i] is unchanged (oldest word kept), and drop_cnt[i] increments, saturating at 2^DROPw-1.
- Grant, each cycle:
  - If tb_full=0 and any pend=1: grant g = first tile with pend=1, searching from last+1 modulo Tile_num.
  - On grant: next cycle wr_en=1, dout=hold[g], src_id=g; pend[g] clears unless recaptured the same cycle; last <= g.
  - Otherwise: next cycle wr_en=0; dout and src_id hold their previous values.
- Latency and throughput:
  - A trigger at edge k sets pend at edge k. The earliest grant is at edge k+1, so wr_en is high in the cycle after edge k+1 (2 cycles from trigger to write).
  - Sustained throughput is one word per cycle in total.
  - With all Tile_num tiles pending continuously, each tile is granted exactly once per Tile_num cycles.
- tb_full=1: no grants and wr_en=0 next cycle. Capture and drop logic continue. tb_full is sampled in the same cycle the grant decision is made.
- ip_select=0 for a tile gates capture only; a word already pending is still drained.
- clear_cnt: all counters go to 0. If a drop occurs in the same cycle, clear wins and the result is 0.
- Saturation: a counter at 2^DROPw-1 stays there until clear_cnt or reset.
- Reset asserted mid-operation: all pending words are discarded and all outputs return to their reset values at that edge; no partial write is issued.
- src_id wraps with the round-robin pointer: after granting Tile_num-1, the search restarts at 0.

Test Plan:
- Reset, then tile 2 triggers once with din=0xDEADBEEF (ip_select=4'b1111, tb_full=0) -> wr_en=1 exactly 2 cycles later with dout=0xDEADBEEF and src_id=2; pend_all returns to 0; no other writes.
- All 4 tiles trigger in the same cycle with words 0xA0..0xA3 -> four consecutive writes in order src_id 0,1,2,3 (pointer at reset value 3); every drop counter stays 0.
- Continuous triggers on all tiles for 40 cycles -> grants rotate 0,1,2,3 with no gaps; each tile is granted 10±1 times; drops accumulate on the tiles re-triggered while pending and not granted.
- Hold tb_full=1 for 5 cycles while tile 1 triggers every cycle -> wr_en stays 0; tile 1 keeps its first word; drop_cnt[1]=4. Release tb_full -> the first word is written with src_id=1.
- With DROPw=8, force 300 drops on tile 0 -> drop_cnt[0]=255. Pulse clear_cnt in the same cycle as another drop -> drop_cnt[0]=0.
- Set ip_select=4'b0111 and trigger tile 3 -> no capture, no drop. Assert reset while tiles 0 and 1 are pending -> pend_all=0 and wr_en=0 on the next cycle; no stale writes after reset deasserts.
